// File: rtl/risk_pkg.sv
// Shared defaults, FSM encoding and width helpers for the strided tile memory.
package risk_pkg;

    localparam int SZ_DEF    = 4;
    localparam int NBANK_DEF = 32;
    localparam int DEPTH_DEF = 1024;
    localparam int DW_DEF    = 18;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_ISSUE,
        S_DRAIN,
        S_RESP
    } state_t;

    function automatic int addr_w(input int nbank, input int depth);
        return $clog2(nbank * depth);
    endfunction

    function automatic int rounds_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/risk_bank.sv
// Single-port bank RAM with a registered read port (1-cycle latency); contents are not reset.
module risk_bank #(
    parameter int DW    = 18,
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DW-1:0]            wdata,
    output logic [DW-1:0]            rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= wdata;
            else    rdata     <= mem[addr];
        end
    end

endmodule

// File: rtl/risk_tile_mem.sv
// Strided SZ x SZ tile load/store over NBANK single-port banks, resolving bank
// conflicts in rounds with same-address merging.
module risk_tile_mem
    import risk_pkg::*;
#(
    parameter  int SZ    = SZ_DEF,
    parameter  int NBANK = NBANK_DEF,
    parameter  int DEPTH = DEPTH_DEF,
    parameter  int DW    = DW_DEF,
    localparam int N     = SZ * SZ,
    localparam int AW    = addr_w(NBANK, DEPTH),
    localparam int RCW   = rounds_w(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [AW-1:0] req_stride_x,
    input  logic [AW-1:0] req_stride_y,
    input  logic [N*DW-1:0] req_wdata,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [N*DW-1:0] resp_rdata,
    output logic [RCW-1:0] resp_rounds
);

    localparam int BW = $clog2(NBANK);
    localparam int RW = $clog2(DEPTH);

    state_t                    state;
    logic                      we_q;
    logic [AW-1:0]             base_q, sx_q, sy_q;
    logic [N-1:0][DW-1:0]      wd_q, rbuf;
    logic [N-1:0][AW-1:0]      addr_q, calc_addr;
    logic [N-1:0][BW-1:0]      el_bank;
    logic [N-1:0][RW-1:0]      el_row;
    logic [N-1:0]              pend, served_q, serve;
    logic [RCW-1:0]            rnd_cnt;

    logic [NBANK-1:0]          b_en;
    logic [NBANK-1:0][RW-1:0]  b_row;
    logic [NBANK-1:0][DW-1:0]  b_wd, b_rd;

    always_comb begin
        for (int k = 0; k < N; k++)
            calc_addr[k] = base_q + AW'(k % SZ) * sx_q + AW'(k / SZ) * sy_q;
    end

    for (genvar k = 0; k < N; k++) begin : g_el
        assign el_bank[k] = addr_q[k][BW-1:0];
        assign el_row[k]  = addr_q[k][AW-1:BW];
    end

    // First loop picks each bank's lowest-index pending winner; second loop serves
    // every pending element sharing that winner's row, so the last (highest-index)
    // member of a merged group supplies the store data.
    always_comb begin
        b_en  = '0;
        b_row = '0;
        b_wd  = '0;
        serve = '0;
        if (state == S_ISSUE) begin
            for (int k = 0; k < N; k++) begin
                if (pend[k] && !b_en[el_bank[k]]) begin
                    b_en[el_bank[k]]  = 1'b1;
                    b_row[el_bank[k]] = el_row[k];
                end
            end
            for (int k = 0; k < N; k++) begin
                if (pend[k] && el_row[k] == b_row[el_bank[k]]) begin
                    serve[k]          = 1'b1;
                    b_wd[el_bank[k]]  = wd_q[k];
                end
            end
        end
    end

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        risk_bank #(.DW(DW), .DEPTH(DEPTH)) u_bank (
            .clk   (clk),
            .en    (b_en[b]),
            .we    (we_q),
            .addr  (b_row[b]),
            .wdata (b_wd[b]),
            .rdata (b_rd[b])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            resp_rdata  <= '0;
            resp_rounds <= '0;
            we_q        <= 1'b0;
            base_q      <= '0;
            sx_q        <= '0;
            sy_q        <= '0;
            wd_q        <= '0;
            addr_q      <= '0;
            rbuf        <= '0;
            pend        <= '0;
            served_q    <= '0;
            rnd_cnt     <= '0;
        end else begin
            served_q <= '0;
            unique case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        we_q      <= req_we;
                        base_q    <= req_addr;
                        sx_q      <= req_stride_x;
                        sy_q      <= req_stride_y;
                        wd_q      <= req_wdata;
                        req_ready <= 1'b0;
                        state     <= S_CALC;
                    end
                end
                S_CALC: begin
                    addr_q  <= calc_addr;
                    pend    <= '1;
                    rbuf    <= '0;
                    rnd_cnt <= '0;
                    state   <= S_ISSUE;
                end
                S_ISSUE: begin
                    pend     <= pend & ~serve;
                    served_q <= serve;
                    rnd_cnt  <= rnd_cnt + RCW'(1);
                    if ((pend & ~serve) == '0) state <= S_DRAIN;
                end
                S_DRAIN: state <= S_RESP;
                S_RESP: begin
                    if (!resp_valid) begin
                        resp_valid  <= 1'b1;
                        resp_rdata  <= rbuf;
                        resp_rounds <= rnd_cnt;
                    end else if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
            // Read data of the previous round lands in the lanes it served.
            if (!we_q) begin
                for (int k = 0; k < N; k++)
                    if (served_q[k]) rbuf[k] <= b_rd[el_bank[k]];
            end
        end
    end

endmodule
